// File: rtl/draw_scheduler.sv
// draw_scheduler: round-robin arbiter for the single VGA pixel-write port.
// Drawers raise level requests; exactly one at a time receives a one-hot
// enable, and its x/y/colour is steered to the VGA adapter until it pulses
// done. A watchdog reclaims the port from any drawer that never finishes.
//
// Handshake: a drawer holds req[i] high until it sees its own done[i] pulse
// accepted. The grant (en[i]) is the "ready" side: while en[i] is high, the
// drawer's x/y/colour is plotted every cycle, including the cycle that
// carries done[i]. After a grant ends (done or watchdog abort) there is always
// one RELEASE cycle plus one IDLE cycle with en low, so a drawer can clear its
// counters before it can be granted again.
module draw_scheduler #(
   parameter int NREQ    = 4,
   parameter int TIMEOUT = 16384,
   parameter int CNT_W   = 14,
   localparam int ID_W   = (NREQ > 1) ? $clog2(NREQ) : 1
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic [NREQ-1:0]   req,
   input  logic [NREQ-1:0]   done,
   input  logic [8*NREQ-1:0] x_in,
   input  logic [7*NREQ-1:0] y_in,
   input  logic [3*NREQ-1:0] colour_in,
   output logic [NREQ-1:0]   en,
   output logic [ID_W-1:0]   grant_id,
   output logic              busy,
   output logic [7:0]        vga_x,
   output logic [6:0]        vga_y,
   output logic [2:0]        vga_colour,
   output logic              vga_plot,
   output logic              timeout_err,
   output logic [1:0]        dbgState
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      GRANT   = 2'd1,
      RELEASE = 2'd2
   } state_t;

   state_t            state;
   logic [ID_W-1:0]   rrPtr;
   logic [CNT_W-1:0]  wdog;
   logic [ID_W-1:0]   winner;
   logic              anyReq;
   logic [ID_W-1:0]   nextPtr;
   logic              wdogExpired;

   assign dbgState = state;

   // Watchdog reaches its limit on the last cycle a grant may be held.
   assign wdogExpired = (wdog == CNT_W'(TIMEOUT - 1));

   // Pointer to the drawer after the current grantee, wrapping at NREQ-1.
   assign nextPtr = (int'(grant_id) == NREQ - 1) ? '0 : grant_id + 1'b1;

   // Round-robin pick: first requesting drawer at or after rrPtr (circular).
   always_comb begin
      int idx;
      anyReq = |req;
      winner = '0;
      idx    = 0;
      // Walk offsets from far to near so the nearest requester is assigned last.
      for (int i = NREQ - 1; i >= 0; i--) begin
         idx = int'(rrPtr) + i;
         if (idx >= NREQ) idx = idx - NREQ;
         if (req[idx]) winner = ID_W'(idx);
      end
   end

   // Arbitration FSM with registered enable, grant index, busy and error pulse.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state       <= IDLE;
         en          <= '0;
         grant_id    <= '0;
         busy        <= 1'b0;
         timeout_err <= 1'b0;
         rrPtr       <= '0;
         wdog        <= '0;
      end else begin
         timeout_err <= 1'b0;
         unique case (state)
            IDLE: begin
               if (anyReq) begin
                  en       <= NREQ'(1) << winner;
                  grant_id <= winner;
                  busy     <= 1'b1;
                  wdog     <= '0;
                  state    <= GRANT;
               end
            end
            GRANT: begin
               if (wdog != '1) wdog <= wdog + 1'b1;
               // A completion that lands on the watchdog limit still counts as done.
               if (done[grant_id]) begin
                  en    <= '0;
                  rrPtr <= nextPtr;
                  state <= RELEASE;
               end else if (wdogExpired) begin
                  en          <= '0;
                  timeout_err <= 1'b1;
                  rrPtr       <= nextPtr;
                  state       <= RELEASE;
               end
            end
            RELEASE: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: begin
               en    <= '0;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

   // Pixel mux: the grantee's coordinates and colour reach the adapter only in GRANT.
   always_comb begin
      vga_plot   = 1'b0;
      vga_x      = '0;
      vga_y      = '0;
      vga_colour = '0;
      if (state == GRANT) begin
         vga_plot   = en[grant_id];
         vga_x      = x_in[8*int'(grant_id) +: 8];
         vga_y      = y_in[7*int'(grant_id) +: 7];
         vga_colour = colour_in[3*int'(grant_id) +: 3];
      end
   end

endmodule
